out_uart_logger: RTL and testbench
==================================

Name: out_uart_logger

Overview:
- Downstream consumer of the processor top-level's 32-bit `io_out` result bus.
- Detects each change of that bus and queues the new value in a small FIFO.
- Serialises queued words over a single 8N1 UART TX line, so program results can be observed on a board pin or decoded in simulation.
- Sits beside the processor in the system wrapper. It adds no load or backpressure on the processor.

Parameters:
- DATA_W, 32: width of the observed bus; must be a multiple of 8.
- FIFO_DEPTH, 8: number of queued words; power of two, at least 2.
- CLKS_PER_BIT, 16: clock cycles per UART bit; at least 2.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- io_in  in  DATA_W  processor `io_out` value.
- en  in  1  capture enable.
- uart_tx  out  1  serial line; idles high.
- busy  out  1  high when the FSM is not IDLE or the FIFO is non-empty.
- fifo_count  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- overflow  out  1  sticky flag: a word was dropped.

Behaviour:
- Reset (reset=0, asynchronous):
  - Register `prev` = 0 and FIFO empty (fifo_count=0).
  - overflow=0, FSM=IDLE, uart_tx=1, busy=0.
  - Effect is immediate, including mid-frame; the partial frame is abandoned.
- Change detect:
  - Push request at a clock edge when en=1 and io_in != prev.
  - `prev` loads io_in on every edge with en=1, whether or not the push is accepted.
  - With en=0, `prev` holds and no pushes occur.
  - Because `prev` resets to 0, a nonzero io_in at the first enabled edge after reset is pushed.
- FIFO:
  - Synchronous, first-in first-out, circular read/write pointers that wrap at FIFO_DEPTH.
  - Push accepted if not full, or if full and a pop occurs on the same edge.
  - A rejected push sets overflow=1; the flag holds until reset.
  - A simultaneous push and pop leaves the count unchanged.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: uart_tx=1. If the FIFO is non-empty, pop the head word into the shift register, set byte_idx=0, go to START.
    - uart_tx drives low from the same edge.
    - Latency: a change sampled at edge k gives uart_tx=0 after edge k+1 when the FSM was idle.
  - START: uart_tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit_idx=0.
  - DATA:
    - Drive byte bits LSB first, each for CLKS_PER_BIT cycles.
    - After bit 7, go to STOP.
  - STOP:
    - uart_tx=1 for CLKS_PER_BIT cycles.
    - If byte_idx < DATA_W/8-1: byte_idx++, go to START with no idle gap.
    - Otherwise go to IDLE.
  - Bytes go out little-endian: bits [7:0] first.
  - One word takes (DATA_W/8)*10*CLKS_PER_BIT cycles, plus at least one IDLE cycle between words.
- Output registering:
  - uart_tx is driven from a register, so it has no glitches.
  - busy and fifo_count are combinational from registered state.
- en does not affect draining: queued words still transmit with en=0.
- The bit-period counter counts 0..CLKS_PER_BIT-1 and restarts on every state or bit transition.

Decomposition:
- Shared package `logger_pkg`:
  - TX state enum (IDLE/START/DATA/STOP).
  - Constant BITS_PER_FRAME=10.
  - Width helper for fifo_count.
- One sub-module, `sync_fifo`, parameterised by width and depth:
  - Outputs full, empty, count.
  - Implements the push-when-full-with-pop rule.
- The FSM and change detection stay in the top of the block.

Test Plan (benches use CLKS_PER_BIT=4, DATA_W=32, FIFO_DEPTH=8):
1. Reset held, then released with io_in=0 and en=1 -> uart_tx=1, busy=0, fifo_count=0, overflow=0; no frame ever starts.
2. io_in 0 -> 0x12345678 at edge k:
   - uart_tx=0 after edge k+1.
   - Decoded bytes are 0x78, 0x56, 0x34, 0x12.
   - Frame lasts 160 cycles, then busy=0.
3. io_in held at 0x12345678 for 500 cycles after test 2 -> no further frames; fifo_count stays 0.
4. Values 1..10 presented on 10 consecutive edges from idle:
   - fifo_count peaks at 8 and overflow=1.
   - Exactly 9 words are transmitted, values 1..9 in order; value 10 is lost.
5. Reset asserted mid-byte-1 of 0xAABBCCDD, io_in held at that value:
   - uart_tx=1 immediately and fifo_count=0.
   - After release, 0xAABBCCDD is re-pushed at the first enabled edge and retransmitted in full.
6. en=0 while io_in goes 5 -> 6 -> 7 (prev=5) -> no push.
   - Set en=1 with io_in=7 -> exactly one word, 7, is transmitted.
   - Words queued before en fell still drain during en=0.

Source files
------------

// File: rtl/logger_pkg.sv
// Shared types and constants for the io_out UART logger.
// Holds the TX state encoding, frame length and FIFO count width helper.
package logger_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } tx_state_e;

    // Start bit + 8 data bits + stop bit.
    localparam int unsigned BITS_PER_FRAME = 10;

    function automatic int unsigned count_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous circular FIFO with a combinational head output.
// A push into a full FIFO is accepted when a pop happens on the same edge.
module sync_fifo
    import logger_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 8
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_push,
    input  logic                        i_pop,
    input  logic [WIDTH-1:0]            i_data,
    output logic [WIDTH-1:0]            o_data,
    output logic                        o_full,
    output logic                        o_empty,
    output logic [count_w(DEPTH)-1:0]   o_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = count_w(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;

    logic w_pop;
    logic w_push;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_count = r_count;
    assign o_data  = r_mem[r_rptr];

    assign w_pop  = i_pop && !o_empty;
    assign w_push = i_push && (!o_full || w_pop);

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

endmodule

// File: rtl/out_uart_logger.sv
// Watches the processor io_out bus, queues every change and sends each queued
// word little-endian over an 8N1 UART line without ever stalling the processor.
module out_uart_logger
    import logger_pkg::*;
#(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [DATA_W-1:0]               io_in,
    input  logic                            en,
    output logic                            uart_tx,
    output logic                            busy,
    output logic [count_w(FIFO_DEPTH)-1:0]  fifo_count,
    output logic                            overflow
);

    localparam int unsigned NBYTES = DATA_W / 8;
    localparam int unsigned CNT_W  = $clog2(CLKS_PER_BIT);
    localparam int unsigned BYTE_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BYTE_W-1:0] BYTE_MAX = BYTE_W'(NBYTES - 1);
    localparam logic [2:0]        LAST_BIT = 3'(BITS_PER_FRAME - 3);

    logic [DATA_W-1:0] r_prev;
    logic              r_overflow;
    tx_state_e         r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [2:0]        r_bit_idx;
    logic [BYTE_W-1:0] r_byte_idx;
    logic [DATA_W-1:0] r_shift;
    logic              r_tx;

    tx_state_e         w_state_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [2:0]        w_bit_nxt;
    logic [BYTE_W-1:0] w_byte_nxt;
    logic [DATA_W-1:0] w_shift_nxt;
    logic              w_tx_nxt;

    logic              w_push_req;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic              w_bit_end;
    logic [DATA_W-1:0] w_head;

    assign w_push_req = en && (io_in != r_prev);
    assign w_bit_end  = (r_cnt == CNT_MAX);

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (clock),
        .i_rst_n (reset),
        .i_push  (w_push_req),
        .i_pop   (w_pop),
        .i_data  (io_in),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (fifo_count)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_prev     <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (en) begin
                r_prev <= io_in;
            end
            if (w_push_req && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= StIdle;
            r_cnt      <= '0;
            r_bit_idx  <= '0;
            r_byte_idx <= '0;
            r_shift    <= '0;
            r_tx       <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_bit_idx  <= w_bit_nxt;
            r_byte_idx <= w_byte_nxt;
            r_shift    <= w_shift_nxt;
            r_tx       <= w_tx_nxt;
        end
    end

    // The line value for the next state is computed here so uart_tx comes straight from r_tx.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + CNT_W'(1);
        w_bit_nxt   = r_bit_idx;
        w_byte_nxt  = r_byte_idx;
        w_shift_nxt = r_shift;
        w_tx_nxt    = r_tx;
        w_pop       = 1'b0;

        unique case (r_state)
            StIdle: begin
                w_cnt_nxt = '0;
                w_tx_nxt  = 1'b1;
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = w_head;
                    w_byte_nxt  = '0;
                    w_state_nxt = StStart;
                    w_tx_nxt    = 1'b0;
                end
            end
            StStart: begin
                if (w_bit_end) begin
                    w_cnt_nxt   = '0;
                    w_bit_nxt   = '0;
                    w_state_nxt = StData;
                    w_tx_nxt    = r_shift[0];
                end
            end
            StData: begin
                if (w_bit_end) begin
                    w_cnt_nxt   = '0;
                    w_shift_nxt = r_shift >> 1;
                    if (r_bit_idx == LAST_BIT) begin
                        w_state_nxt = StStop;
                        w_tx_nxt    = 1'b1;
                    end else begin
                        w_bit_nxt = r_bit_idx + 3'd1;
                        w_tx_nxt  = r_shift[1];
                    end
                end
            end
            StStop: begin
                if (w_bit_end) begin
                    w_cnt_nxt = '0;
                    if (r_byte_idx < BYTE_MAX) begin
                        w_byte_nxt  = r_byte_idx + BYTE_W'(1);
                        w_state_nxt = StStart;
                        w_tx_nxt    = 1'b0;
                    end else begin
                        w_state_nxt = StIdle;
                        w_tx_nxt    = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = StIdle;
                w_tx_nxt    = 1'b1;
            end
        endcase
    end

    assign uart_tx  = r_tx;
    assign busy     = (r_state != StIdle) || !w_empty;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_out_uart_logger.sv
// Directed bench for out_uart_logger: a UART receiver model decodes the line and
// compares each word against a scoreboard filled as stimulus is driven.
module tb_out_uart_logger;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned FIFO_DEPTH = 8;
    localparam int unsigned CPB        = 4;
    localparam int unsigned NBYTES     = DATA_W / 8;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [DATA_W-1:0] io_in = '0;
    logic              en    = 1'b1;
    logic              uart_tx;
    logic              busy;
    logic [3:0]        fifo_count;
    logic              overflow;

    int n_tests  = 0;
    int n_fail   = 0;
    int words_rx = 0;

    logic [DATA_W-1:0] sb [$];

    out_uart_logger #(
        .DATA_W       (DATA_W),
        .FIFO_DEPTH   (FIFO_DEPTH),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .io_in      (io_in),
        .en         (en),
        .uart_tx    (uart_tx),
        .busy       (busy),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drain(input string tag, input int budget);
        int i = 0;
        while ((sb.size() != 0 || busy) && i < budget) begin
            tick();
            i++;
        end
        check(tag, 32'(i < budget), 32'd1);
    endtask

    // UART receiver model: samples each bit at the middle of its period.
    logic              m_active = 1'b0;
    int                m_cnt    = 0;
    int                m_nb     = 0;
    logic [7:0]        m_byte   = '0;
    logic [DATA_W-1:0] m_word   = '0;

    always @(negedge clock) begin
        if (!reset) begin
            m_active = 1'b0;
            m_nb     = 0;
            m_word   = '0;
        end else if (!m_active) begin
            if (uart_tx === 1'b0) begin
                m_active = 1'b1;
                m_cnt    = 0;
            end
        end else begin
            m_cnt++;
            if (m_cnt == 2) begin
                check("start_bit", 32'(uart_tx), 32'd0);
            end else if (m_cnt >= 6 && m_cnt <= 34 && (m_cnt - 2) % 4 == 0) begin
                m_byte[(m_cnt - 6) / 4] = uart_tx;
            end else if (m_cnt == 38) begin
                check("stop_bit", 32'(uart_tx), 32'd1);
                m_word[8*m_nb +: 8] = m_byte;
                m_nb++;
                m_active = 1'b0;
                if (m_nb == NBYTES) begin
                    m_nb = 0;
                    words_rx++;
                    if (sb.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $error("FAIL unexpected_word: observed 0x%0h expected none", m_word);
                    end else begin
                        check("rx_word", m_word, sb.pop_front());
                    end
                    m_word = '0;
                end
            end
        end
    end

    initial begin
        int w0;
        int maxc;
        logic flag;

        // 1: reset, then quiet line with io_in=0
        #2 reset = 1'b0;
        repeat (3) tick();
        check("rst_tx", 32'(uart_tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        reset = 1'b1;
        flag  = 1'b0;
        repeat (50) begin
            tick();
            if (uart_tx !== 1'b1 || busy !== 1'b0 || fifo_count !== 4'd0) flag = 1'b1;
        end
        check("t1_quiet", 32'(flag), 32'd0);

        // 2: single word, latency and frame length
        w0    = words_rx;
        io_in = 32'h1234_5678;
        sb.push_back(io_in);
        tick();
        check("t2_tx_edge_k", 32'(uart_tx), 32'd1);
        check("t2_count_edge_k", 32'(fifo_count), 32'd1);
        tick();
        check("t2_tx_edge_k1", 32'(uart_tx), 32'd0);
        check("t2_count_edge_k1", 32'(fifo_count), 32'd0);
        repeat (159) tick();
        check("t2_busy_last_cycle", 32'(busy), 32'd1);
        tick();
        check("t2_busy_done", 32'(busy), 32'd0);
        check("t2_words", 32'(words_rx), 32'(w0 + 1));
        check("t2_sb_empty", 32'(sb.size()), 32'd0);

        // 3: held value produces nothing
        w0   = words_rx;
        flag = 1'b0;
        repeat (500) begin
            tick();
            if (uart_tx !== 1'b1 || fifo_count !== 4'd0) flag = 1'b1;
        end
        check("t3_quiet", 32'(flag), 32'd0);
        check("t3_words", 32'(words_rx), 32'(w0));

        // 4: burst of 10; one goes straight to the shifter, eight fill the FIFO, 10 is lost
        w0   = words_rx;
        maxc = 0;
        for (int v = 1; v <= 10; v++) begin
            io_in = 32'(v);
            if (v <= 9) sb.push_back(io_in);
            tick();
            if (int'(fifo_count) > maxc) maxc = int'(fifo_count);
        end
        check("t4_peak_count", 32'(maxc), 32'd8);
        check("t4_overflow", 32'(overflow), 32'd1);
        drain("t4_drain_timeout", 9 * 170);
        check("t4_words", 32'(words_rx), 32'(w0 + 9));
        check("t4_overflow_sticky", 32'(overflow), 32'd1);

        // 5: reset in the middle of byte 1
        w0    = words_rx;
        io_in = 32'hAABB_CCDD;
        sb.push_back(io_in);
        repeat (61) tick();
        check("t5_mid_frame_busy", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        check("t5_rst_tx", 32'(uart_tx), 32'd1);
        check("t5_rst_count", 32'(fifo_count), 32'd0);
        check("t5_rst_busy", 32'(busy), 32'd0);
        check("t5_rst_overflow", 32'(overflow), 32'd0);
        sb.delete();
        repeat (3) tick();
        reset = 1'b1;
        sb.push_back(io_in);
        tick();
        check("t5_repush_count", 32'(fifo_count), 32'd1);
        drain("t5_drain_timeout", 300);
        check("t5_words", 32'(words_rx), 32'(w0 + 1));

        // 6: en gating of capture, not of draining
        w0    = words_rx;
        io_in = 32'd4;
        sb.push_back(io_in);
        tick();
        io_in = 32'd5;
        sb.push_back(io_in);
        tick();
        check("t6_count_before_en_low", 32'(fifo_count), 32'd1);
        en    = 1'b0;
        io_in = 32'd6;
        tick();
        io_in = 32'd7;
        tick();
        check("t6_count_en_low", 32'(fifo_count), 32'd1);
        drain("t6_drain_en_low_timeout", 2 * 170);
        check("t6_words_en_low", 32'(words_rx), 32'(w0 + 2));
        en = 1'b1;
        sb.push_back(io_in);
        tick();
        check("t6_count_en_high", 32'(fifo_count), 32'd1);
        drain("t6_drain_timeout", 200);
        check("t6_words", 32'(words_rx), 32'(w0 + 3));
        check("t6_sb_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
